// File: rtl/bsg_profiler_counter_bank.sv
// Multi-channel event counter bank: atomic snapshot into shadows, drained one channel per valid/yumi beat.
// Optional sticky per-channel overflow flags are enabled by defining BSG_PROFILER_OVERFLOW_EN.
module bsg_profiler_counter_bank #(
    parameter int els_p               = 32,
    parameter int width_p             = 32,
    parameter int saturate_p          = 0,
    parameter int clear_on_snapshot_p = 1,
    parameter int lg_els_lp           = (els_p == 1) ? 1 : $clog2(els_p)
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 enable_i,
    input  logic [els_p-1:0]     countme_i,
    input  logic                 snapshot_v_i,
    output logic                 snapshot_ready_o,
    output logic                 v_o,
    output logic [width_p-1:0]   data_o,
    output logic [lg_els_lp-1:0] id_o,
    output logic                 last_o,
    input  logic                 yumi_i,
    output logic                 ovf_o
);
    typedef enum logic {eIdle, eDrain} state_e;

    localparam logic [lg_els_lp-1:0] last_idx_lp = lg_els_lp'(els_p - 1);

    state_e               state, state_next;
    logic [lg_els_lp-1:0] index, index_next;
    logic [width_p-1:0]   live      [els_p];
    logic [width_p-1:0]   live_next [els_p];
    logic [width_p-1:0]   shadow    [els_p];
    logic [els_p-1:0]     hit, at_max;
    logic                 accept, at_last;

    assign hit     = countme_i & {els_p{enable_i}};
    assign accept  = snapshot_v_i & snapshot_ready_o;
    assign at_last = (index == last_idx_lp);

    // A clearing snapshot restarts each counter from the event seen on the same edge
    always_comb begin
        for (int unsigned k = 0; k < els_p; k++) begin
            at_max[k]    = &live[k];
            live_next[k] = live[k];
            if (accept && (clear_on_snapshot_p != 0))
                live_next[k] = hit[k] ? width_p'(1) : '0;
            else if (hit[k] && !((saturate_p != 0) && at_max[k]))
                live_next[k] = live[k] + width_p'(1);
        end
    end

    always_comb begin
        state_next       = state;
        index_next       = index;
        snapshot_ready_o = 1'b0;
        v_o              = 1'b0;
        id_o             = '0;
        last_o           = 1'b0;
        case (state)
            eIdle: begin
                snapshot_ready_o = 1'b1;
                if (snapshot_v_i) begin
                    state_next = eDrain;
                    index_next = '0;
                end
            end
            eDrain: begin
                v_o    = 1'b1;
                id_o   = index;
                last_o = at_last;
                if (yumi_i) begin
                    if (at_last) begin
                        state_next = eIdle;
                        index_next = '0;
                    end else begin
                        index_next = index + lg_els_lp'(1);
                    end
                end
            end
            default: state_next = eIdle;
        endcase
    end

    assign data_o = v_o ? shadow[index] : '0;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state <= eIdle;
            index <= '0;
            for (int unsigned k = 0; k < els_p; k++) begin
                live[k]   <= '0;
                shadow[k] <= '0;
            end
        end else begin
            state <= state_next;
            index <= index_next;
            for (int unsigned k = 0; k < els_p; k++) begin
                live[k] <= live_next[k];
                if (accept)
                    shadow[k] <= live[k];
            end
        end
    end

`ifdef BSG_PROFILER_OVERFLOW_EN
    logic [els_p-1:0] ovf_live, ovf_shadow;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ovf_live   <= '0;
            ovf_shadow <= '0;
        end else begin
            if (accept)
                ovf_shadow <= ovf_live;
            if (accept && (clear_on_snapshot_p != 0))
                ovf_live <= '0;
            else
                ovf_live <= ovf_live | (hit & at_max);
        end
    end

    assign ovf_o = v_o & ovf_shadow[index];
`else
    assign ovf_o = 1'b0;
`endif

`ifndef SYNTHESIS
    assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o)
        else $error("yumi_i asserted while v_o is low");
    assert property (@(posedge clk_i) disable iff (reset_i) enable_i |-> !$isunknown(countme_i))
        else $error("countme_i unknown while enable_i is high");
`endif

endmodule
